// File: rtl/manhattan_pkg.sv
// Shared definitions for the Manhattan distance streamer and distance core:
// default vector geometry, index widths and the streamer state encoding.
package manhattan_pkg;

    localparam int DATA_W  = 8;
    localparam int VEC_LEN = 16;
    localparam int NUM_TPL = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TPL_W  = idx_w(NUM_TPL);
    localparam int ADDR_W = idx_w(VEC_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/manhattan_vec_buf.sv
// Vector storage: NUM_VEC vectors of VEC_LEN elements, one write port and a
// combinational read port. Contents are deliberately left out of reset.
module manhattan_vec_buf #(
    parameter int DATA_W  = 8,
    parameter int NUM_VEC = 1,
    parameter int VEC_LEN = 16,
    parameter int TPL_W   = 1,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [TPL_W-1:0]  wr_tpl,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TPL_W-1:0]  rd_tpl,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    import manhattan_pkg::*;

    localparam int DEPTH = NUM_VEC * VEC_LEN;
    localparam int IDX_W = idx_w(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [IDX_W-1:0]  wr_idx_s;
    logic [IDX_W-1:0]  rd_idx_s;

    assign wr_idx_s = IDX_W'(32'(wr_tpl) * 32'(VEC_LEN) + 32'(wr_addr));
    assign rd_idx_s = IDX_W'(32'(rd_tpl) * 32'(VEC_LEN) + 32'(rd_addr));

    // Storage write; the caller guarantees the index is in range.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx_s] <= wr_data;
        end
    end

    // Combinational read, registered by the streamer.
    always_comb begin
        rd_data = mem_r[rd_idx_s];
    end

endmodule

// File: rtl/manhattan_vector_streamer.sv
// Source end of the Manhattan distance interface: holds X and the templates,
// and on Start streams (X[i], T_k[i]) pairs with framing and template id.
module manhattan_vector_streamer #(
    parameter int  DATA_W     = manhattan_pkg::DATA_W,
    parameter int  VEC_LEN    = manhattan_pkg::VEC_LEN,
    parameter int  NUM_TPL    = manhattan_pkg::NUM_TPL,
    parameter int  GAP_CYCLES = 1,
    localparam int TPL_W      = manhattan_pkg::idx_w(NUM_TPL),
    localparam int ADDR_W     = manhattan_pkg::idx_w(VEC_LEN)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WrEn,
    input  logic              WrSel,
    input  logic [TPL_W-1:0]  WrTpl,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Start,
    output logic [DATA_W-1:0] X,
    output logic [DATA_W-1:0] T,
    output logic              Valid,
    input  logic              Ready,
    output logic              First,
    output logic              Last,
    output logic [TPL_W-1:0]  TplId,
    output logic              Busy,
    output logic              Done
);
    import manhattan_pkg::*;

    localparam int GAP_W    = idx_w(GAP_CYCLES);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_e            state_r;
    logic [ADDR_W-1:0] elem_r;
    logic [ADDR_W-1:0] nxt_elem_s;
    logic [TPL_W-1:0]  tpl_r;
    logic [TPL_W-1:0]  nxt_tpl_s;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              xfer_s;
    logic              tpl_last_s;
    logic              nxt_first_s;
    logic              nxt_last_s;
    logic              addr_ok_s;
    logic              tpl_ok_s;
    logic              wr_ok_s;
    logic [DATA_W-1:0] x_rd_s;
    logic [DATA_W-1:0] t_rd_s;

    assign xfer_s      = Valid && Ready;
    assign tpl_last_s  = (tpl_r == TPL_W'(NUM_TPL - 1));
    assign nxt_first_s = (nxt_elem_s == '0);
    assign nxt_last_s  = (nxt_elem_s == ADDR_W'(VEC_LEN - 1));
    assign addr_ok_s   = ({1'b0, WrAddr} < (ADDR_W + 1)'(VEC_LEN));
    assign tpl_ok_s    = !WrSel || ({1'b0, WrTpl} < (TPL_W + 1)'(NUM_TPL));
    // Start has priority over a coincident write.
    assign wr_ok_s     = WrEn && !Start && (state_r == IDLE) && addr_ok_s && tpl_ok_s;

    manhattan_vec_buf #(
        .DATA_W (DATA_W), .NUM_VEC(1), .VEC_LEN(VEC_LEN), .TPL_W(1), .ADDR_W(ADDR_W)
    ) u_x_buf (
        .clk    (Clk),
        .wr_en  (wr_ok_s && !WrSel),
        .wr_tpl (1'b0),
        .wr_addr(WrAddr),
        .wr_data(WrData),
        .rd_tpl (1'b0),
        .rd_addr(nxt_elem_s),
        .rd_data(x_rd_s)
    );

    manhattan_vec_buf #(
        .DATA_W (DATA_W), .NUM_VEC(NUM_TPL), .VEC_LEN(VEC_LEN), .TPL_W(TPL_W), .ADDR_W(ADDR_W)
    ) u_t_buf (
        .clk    (Clk),
        .wr_en  (wr_ok_s && WrSel),
        .wr_tpl (WrTpl),
        .wr_addr(WrAddr),
        .wr_data(WrData),
        .rd_tpl (nxt_tpl_s),
        .rd_addr(nxt_elem_s),
        .rd_data(t_rd_s)
    );

    // Index of the beat to present after this edge; also the buffer read address.
    always_comb begin
        nxt_elem_s = elem_r;
        nxt_tpl_s  = tpl_r;
        case (state_r)
            IDLE: begin
                nxt_elem_s = '0;
                nxt_tpl_s  = '0;
            end
            STREAM: begin
                if (xfer_s && !Last) begin
                    nxt_elem_s = elem_r + 1'b1;
                end else if (xfer_s && !tpl_last_s) begin
                    nxt_elem_s = '0;
                    nxt_tpl_s  = tpl_r + 1'b1;
                end else begin
                    nxt_elem_s = elem_r;
                    nxt_tpl_s  = tpl_r;
                end
            end
            default: begin
                nxt_elem_s = elem_r;
                nxt_tpl_s  = tpl_r;
            end
        endcase
    end

    // Streaming FSM with all interface outputs registered.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= IDLE;
            elem_r    <= '0;
            tpl_r     <= '0;
            gap_cnt_r <= '0;
            X         <= '0;
            T         <= '0;
            Valid     <= 1'b0;
            First     <= 1'b0;
            Last      <= 1'b0;
            TplId     <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        state_r <= STREAM;
                        elem_r  <= nxt_elem_s;
                        tpl_r   <= nxt_tpl_s;
                        Busy    <= 1'b1;
                        Valid   <= 1'b1;
                        First   <= nxt_first_s;
                        Last    <= nxt_last_s;
                        TplId   <= nxt_tpl_s;
                        X       <= x_rd_s;
                        T       <= t_rd_s;
                    end
                end
                STREAM: begin
                    if (xfer_s) begin
                        elem_r <= nxt_elem_s;
                        tpl_r  <= nxt_tpl_s;
                        if (!Last || (!tpl_last_s && GAP_CYCLES == 0)) begin
                            Valid <= 1'b1;
                            First <= nxt_first_s;
                            Last  <= nxt_last_s;
                            TplId <= nxt_tpl_s;
                            X     <= x_rd_s;
                            T     <= t_rd_s;
                        end else if (!tpl_last_s) begin
                            state_r   <= GAP;
                            gap_cnt_r <= '0;
                            Valid     <= 1'b0;
                            First     <= 1'b0;
                            Last      <= 1'b0;
                        end else begin
                            state_r <= DONE;
                            Valid   <= 1'b0;
                            First   <= 1'b0;
                            Last    <= 1'b0;
                            Busy    <= 1'b0;
                            Done    <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_W'(GAP_LAST)) begin
                        state_r <= STREAM;
                        Valid   <= 1'b1;
                        First   <= nxt_first_s;
                        Last    <= nxt_last_s;
                        TplId   <= nxt_tpl_s;
                        X       <= x_rd_s;
                        T       <= t_rd_s;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_manhattan_vector_streamer.sv
// Self-checking bench: a cycle-schedule reference model of the stream is built
// from the interface rules and compared beat by beat against three DUT instances.
module tb_manhattan_vector_streamer;

    localparam int MAXC = 400;
    localparam int VL   = 16;

    logic       clk = 1'b0;
    logic       rst, wr_en, wr_en_r, wr_sel, wr_tpl_m, start, ready, aux_en, start_x;
    logic [1:0] wr_tpl_r;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    logic [7:0] x, t, g_x, g_t, r_x, r_t;
    logic       valid, first, last, tpl_id, busy, done;
    logic       g_valid, g_first, g_last, g_tpl, g_busy, g_done;
    logic       r_valid, r_first, r_last, r_busy, r_done;
    logic [1:0] r_tpl;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] xv [VL];
    logic [7:0] tv [2][VL];
    logic [7:0] xr [VL];
    logic [7:0] tr [3][VL];
    bit         rdy_a [MAXC];
    bit         ev [MAXC];
    int         eb [MAXC];

    assign start_x = start && aux_en;

    always #5 clk = ~clk;

    manhattan_vector_streamer dut (
        .Clk(clk), .Rst(rst), .WrEn(wr_en), .WrSel(wr_sel), .WrTpl(wr_tpl_m),
        .WrAddr(wr_addr), .WrData(wr_data), .Start(start), .X(x), .T(t),
        .Valid(valid), .Ready(ready), .First(first), .Last(last), .TplId(tpl_id),
        .Busy(busy), .Done(done)
    );

    manhattan_vector_streamer #(.GAP_CYCLES(0)) dut_g (
        .Clk(clk), .Rst(rst), .WrEn(wr_en), .WrSel(wr_sel), .WrTpl(wr_tpl_m),
        .WrAddr(wr_addr), .WrData(wr_data), .Start(start_x), .X(g_x), .T(g_t),
        .Valid(g_valid), .Ready(ready), .First(g_first), .Last(g_last), .TplId(g_tpl),
        .Busy(g_busy), .Done(g_done)
    );

    manhattan_vector_streamer #(.NUM_TPL(3), .VEC_LEN(12)) dut_r (
        .Clk(clk), .Rst(rst), .WrEn(wr_en_r), .WrSel(wr_sel), .WrTpl(wr_tpl_r),
        .WrAddr(wr_addr), .WrData(wr_data), .Start(start_x), .X(r_x), .T(r_t),
        .Valid(r_valid), .Ready(ready), .First(r_first), .Last(r_last), .TplId(r_tpl),
        .Busy(r_busy), .Done(r_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, x, 8'd0);
        chk({tag, "_t"}, t, 8'd0);
        chk({tag, "_valid"}, valid, 1'b0);
        chk({tag, "_first"}, first, 1'b0);
        chk({tag, "_last"}, last, 1'b0);
        chk({tag, "_tplid"}, tpl_id, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    task automatic wr(input logic en_m, input logic en_r, input logic sel, input logic [1:0] tp,
                      input logic [3:0] addr, input logic [7:0] d);
        wr_en = en_m; wr_en_r = en_r; wr_sel = sel;
        wr_tpl_m = tp[0]; wr_tpl_r = tp; wr_addr = addr; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0; wr_en_r = 1'b0;
    endtask

    // Reference schedule: Ready pattern per cycle (cycle 0 = Start cycle) and
    // which beat, if any, the main DUT should present in each cycle.
    task automatic plan(input int mode, output int done_c);
        int tc, s;
        for (int c = 0; c < MAXC; c++) begin
            if (mode == 0 || c >= 300) rdy_a[c] = 1'b1;
            else if (mode == 1)        rdy_a[c] = (c % 2 == 1);
            else                       rdy_a[c] = ($urandom_range(0, 3) != 0);
            ev[c] = 1'b0;
            eb[c] = 0;
        end
        tc = 1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < VL; i++) begin
                s = tc;
                while (!rdy_a[tc]) tc++;
                for (int c = s; c <= tc; c++) begin
                    ev[c] = 1'b1;
                    eb[c] = k * VL + i;
                end
                tc++;
            end
            if (k < 1) tc += 1;
        end
        done_c = tc;
    endtask

    // One streaming run; wr_c/st_c inject an X[0] write / extra Start in that cycle.
    task automatic run(input int mode, input int wr_c, input int st_c);
        int done_c, last_c, k, i, kg, ig, kr, ir;
        plan(mode, done_c);
        last_c = (mode == 0 && done_c < 40) ? 40 : done_c;
        aux_en = (mode == 0);
        wr_sel = 1'b0; wr_tpl_m = 1'b0; wr_tpl_r = 2'd0; wr_addr = 4'd0; wr_data = 8'h55;
        start = 1'b1; wr_en = (wr_c == 0); ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= last_c; c++) begin
            ready = rdy_a[c];
            start = (c == st_c);
            wr_en = (c == wr_c);
            @(negedge clk);
            chk("valid", valid, ev[c]);
            if (ev[c]) begin
                k = eb[c] / VL;
                i = eb[c] % VL;
                chk("x", x, xv[i]);
                chk("t", t, tv[k][i]);
                chk("first", first, (i == 0));
                chk("last", last, (i == VL - 1));
                chk("tplid", tpl_id, k[0]);
            end
            chk("done", done, (c == done_c));
            chk("busy", busy, (c < done_c));
            if (mode == 0) begin
                if (c <= 32) begin
                    kg = (c - 1) / VL;
                    ig = (c - 1) % VL;
                    chk("gap0_valid", g_valid, 1'b1);
                    chk("gap0_x", g_x, xv[ig]);
                    chk("gap0_t", g_t, tv[kg][ig]);
                    chk("gap0_first", g_first, (ig == 0));
                    chk("gap0_last", g_last, (ig == VL - 1));
                    chk("gap0_tplid", g_tpl, kg[0]);
                end else begin
                    chk("gap0_idle", g_valid, 1'b0);
                end
                chk("gap0_done", g_done, (c == 33));
                kr = (c - 1) / 13;
                ir = (c - 1) % 13;
                if (c <= 38 && ir < 12) begin
                    chk("rng_valid", r_valid, 1'b1);
                    chk("rng_x", r_x, xr[ir]);
                    chk("rng_t", r_t, tr[kr][ir]);
                    chk("rng_tplid", r_tpl, kr[1:0]);
                end else begin
                    chk("rng_idle", r_valid, 1'b0);
                end
                chk("rng_done", r_done, (c == 39));
            end
            @(posedge clk); #1;
        end
        start = 1'b0; wr_en = 1'b0; aux_en = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        rst = 1'b1; wr_en = 1'b0; wr_en_r = 1'b0; wr_sel = 1'b0; wr_tpl_m = 1'b0;
        wr_tpl_r = 2'd0; wr_addr = 4'd0; wr_data = 8'd0; start = 1'b0; ready = 1'b0; aux_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors for the main and zero-gap instances.
        for (int i = 0; i < VL; i++) begin
            xv[i] = 8'(i + 1);     wr(1'b1, 1'b0, 1'b0, 2'd0, 4'(i), xv[i]);
            tv[0][i] = 8'(2 * i);  wr(1'b1, 1'b0, 1'b1, 2'd0, 4'(i), tv[0][i]);
            tv[1][i] = 8'(-i);     wr(1'b1, 1'b0, 1'b1, 2'd1, 4'(i), tv[1][i]);
        end
        // Range instance: every WrTpl/WrAddr combination, only in-range ones land.
        for (int a = 0; a < VL; a++) begin
            d = 8'($urandom);
            wr(1'b0, 1'b1, 1'b0, 2'd0, 4'(a), d);
            if (a < 12) xr[a] = d;
        end
        for (int tp = 0; tp < 4; tp++) begin
            for (int a = 0; a < VL; a++) begin
                d = 8'($urandom);
                wr(1'b0, 1'b1, 1'b1, 2'(tp), 4'(a), d);
                if (tp < 3 && a < 12) tr[tp][a] = d;
            end
        end

        run(0, -1, -1);
        run(1, -1, -1);
        run(2, -1, -1);

        // Write and Start while busy are both ignored.
        run(0, 5, 8);
        run(0, -1, -1);

        // Reset during beat 10 of T0 aborts without Done.
        aux_en = 1'b0; ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_pre_x", x, xv[10]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("rst_no_done", done, 1'b0);
            chk("rst_no_valid", valid, 1'b0);
        end
        @(posedge clk); #1;
        run(0, -1, -1);

        // Start and write in the same idle cycle: write dropped.
        run(0, 0, -1);
        run(0, -1, -1);

        // Random contents with random backpressure.
        for (int i = 0; i < VL; i++) begin
            xv[i] = 8'($urandom);    wr(1'b1, 1'b0, 1'b0, 2'd0, 4'(i), xv[i]);
            tv[0][i] = 8'($urandom); wr(1'b1, 1'b0, 1'b1, 2'd0, 4'(i), tv[0][i]);
            tv[1][i] = 8'($urandom); wr(1'b1, 1'b0, 1'b1, 2'd1, 4'(i), tv[1][i]);
        end
        run(2, -1, -1);
        run(1, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
